// File: rtl/div_seq_rv.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Multi-cycle, flushable, with a last-result companion cache.
module div_seq_rv #(
  parameter int DW       = 32,
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic [1:0]       op_i,
  input  logic [DW-1:0]    dividend_i,
  input  logic [DW-1:0]    divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic [DW-1:0]    result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             wd_en,
  output logic             busy_o
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [DW-1:0] ONES = '1;
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state;

  logic [CW-1:0]    cnt;
  logic [DW:0]      rem_r;
  logic [DW-1:0]    quo_r;
  logic [DW-1:0]    dvs_r;
  logic [DW-1:0]    a_r;
  logic [DW-1:0]    b_r;
  logic             neg_q;
  logic             neg_r;
  logic [1:0]       op_r;
  logic [TAG_W-1:0] tag_r;
  logic [DW-1:0]    q_res;
  logic [DW-1:0]    r_res;

  logic             c_vld;
  logic             c_sgn;
  logic [DW-1:0]    c_a;
  logic [DW-1:0]    c_b;
  logic [DW-1:0]    c_q;
  logic [DW-1:0]    c_r;

  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic             hit;
  logic             fast;
  logic [DW-1:0]    a_mag;
  logic [DW-1:0]    b_mag;
  logic [DW-1:0]    f_q;
  logic [DW-1:0]    f_r;

  logic [DW+1:0]    trial;
  logic [DW+1:0]    diff;
  logic             ge;
  logic [DW:0]      rem_nx;
  logic [DW-1:0]    quo_nx;
  logic [DW-1:0]    fin_q;
  logic [DW-1:0]    fin_r;

  // Accept-side decode: magnitudes, signs and single-cycle results
  always_comb begin
    sgn   = ~op_i[0];
    a_neg = sgn & dividend_i[DW-1];
    b_neg = sgn & divisor_i[DW-1];
    a_mag = a_neg ? -dividend_i : dividend_i;
    b_mag = b_neg ? -divisor_i : divisor_i;
    hit   = CACHE_EN && c_vld &&
            (c_a == dividend_i) &&
            (c_b == divisor_i) &&
            (c_sgn == sgn);
    fast  = 1'b1;
    f_q   = c_q;
    f_r   = c_r;
    if (divisor_i == '0) begin
      f_q = ONES;
      f_r = dividend_i;
    end else if (sgn && dividend_i == MINV &&
                 divisor_i == ONES) begin
      f_q = dividend_i;
      f_r = '0;
    end else if (!hit) begin
      fast = 1'b0;
    end
  end

  // One restoring step; the dividend shifts out of quo_r MSB first
  always_comb begin
    trial  = {rem_r, quo_r[DW-1]};
    ge     = trial >= {2'b00, dvs_r};
    diff   = trial - {2'b00, dvs_r};
    rem_nx = ge ? diff[DW:0] : trial[DW:0];
    quo_nx = {quo_r[DW-2:0], ge};
    fin_q  = neg_q ? -quo_nx : quo_nx;
    fin_r  = neg_r ? -rem_nx[DW-1:0] : rem_nx[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result_o <= '0;
      tag_o    <= '0;
      wd_en    <= 1'b0;
      busy_o   <= 1'b0;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      op_r     <= '0;
      tag_r    <= '0;
      q_res    <= '0;
      r_res    <= '0;
      c_vld    <= 1'b0;
      c_sgn    <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      wd_en  <= 1'b0;
      busy_o <= 1'b0;
      cnt    <= '0;
      c_vld  <= 1'b0;
    end else begin
      wd_en <= 1'b0;
      unique case (state)
        IDLE: ;
        CALC: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= FIN;
            busy_o <= 1'b0;
            q_res  <= fin_q;
            r_res  <= fin_r;
            if (CACHE_EN) begin
              c_vld <= 1'b1;
              c_sgn <= ~op_r[0];
              c_a   <= a_r;
              c_b   <= b_r;
              c_q   <= fin_q;
              c_r   <= fin_r;
            end
          end
        end
        FIN: begin
          wd_en    <= 1'b1;
          result_o <= op_r[1] ? r_res : q_res;
          tag_o    <= tag_r;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Later assignments win, so an accept in FIN chains directly
      if (div_en && state != CALC) begin
        op_r  <= op_i;
        tag_r <= tag_i;
        a_r   <= dividend_i;
        b_r   <= divisor_i;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        quo_r <= a_mag;
        dvs_r <= b_mag;
        rem_r <= '0;
        cnt   <= '0;
        if (fast) begin
          state <= FIN;
          q_res <= f_q;
          r_res <= f_r;
        end else begin
          state  <= CALC;
          busy_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq_rv.sv
// Bench for div_seq_rv: directed steps plus random ops
// against an arithmetic reference with a last-op cache model.
module tb_div_seq_rv;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_en;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  tag_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic [4:0]  tag_o;
  logic        wd_en;
  logic        busy_o;

  div_seq_rv #(.DW(32), .TAG_W(5), .CACHE_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_en     (div_en),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .tag_i      (tag_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .tag_o      (tag_o),
    .wd_en      (wd_en),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  int n_chk = 0;
  int n_err = 0;

  bit          m_vld = 1'b0;
  bit          m_sgn;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [31:0] exp_res;
  logic [4:0]  exp_tag;
  int          exp_lat;

  task automatic chk(input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h",
             nm, obs, exp);
    end
  endtask

  // Reference: RISC-V division rules plus the last-op cache
  task automatic predict(input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    bit sgn;
    bit ovf;
    bit fast;
    sgn = !op[0];
    sa  = a;
    sb  = b;
    ovf = sgn && a == MINV && b == ONES;
    if (b == 0) begin
      q = ONES;
      r = a;
    end else if (ovf) begin
      q = a;
      r = 0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    fast = (b == 0) || ovf ||
           (m_vld && m_a == a && m_b == b && m_sgn == sgn);
    exp_lat = fast ? 1 : 33;
    exp_res = op[1] ? r : q;
    if (!fast) begin
      m_vld = 1'b1;
      m_a   = a;
      m_b   = b;
      m_sgn = sgn;
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    tag_i      = tag;
    div_en     = 1'b1;
    predict(op, a, b);
    exp_tag = tag;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input string nm);
    int lat;
    bit busy_seen;
    lat = 0;
    busy_seen = busy_o;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      div_en = 1'b0;
      @(posedge clk);
      #1;
      lat = n;
      busy_seen = busy_seen | busy_o;
      if (wd_en) break;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, result_o, exp_res);
    chk({nm, "_tag"}, {27'd0, tag_o}, {27'd0, exp_tag});
    chk({nm, "_busy"}, {31'd0, busy_seen},
        {31'd0, exp_lat != 1});
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, {31'd0, wd_en}, 32'd0);
  endtask

  initial begin
    logic [31:0] sav_res;
    logic [4:0]  sav_tag;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    int          pulses;
    int          sel;

    rst        = 1'b1;
    div_en     = 1'b0;
    flush_i    = 1'b0;
    op_i       = 2'b00;
    dividend_i = '0;
    divisor_i  = '0;
    tag_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", {27'd0, tag_o}, 32'd0);
    chk("rst_wd", {31'd0, wd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
    collect("div_m7_2");
    chk("div_m7_2_k", result_o, 32'hFFFF_FFFD);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
    collect("rem_m7_2");
    chk("rem_m7_2_k", result_o, 32'hFFFF_FFFF);

    issue(2'b01, 32'd100, 32'd0, 5'd3);
    collect("divu_z");
    chk("divu_z_k", result_o, ONES);
    issue(2'b11, 32'd100, 32'd0, 5'd4);
    collect("remu_z");
    chk("remu_z_k", result_o, 32'd100);
    issue(2'b00, MINV, ONES, 5'd5);
    collect("div_ovf");
    chk("div_ovf_k", result_o, MINV);
    issue(2'b10, MINV, ONES, 5'd6);
    collect("rem_ovf");
    chk("rem_ovf_k", result_o, 32'd0);

    issue(2'b01, ONES, 32'd1, 5'd7);
    collect("divu_max");
    chk("divu_max_k", result_o, ONES);
    issue(2'b10, 32'd20, 32'hFFFF_FFFD, 5'd8);
    collect("rem_20_m3");
    chk("rem_20_m3_k", result_o, 32'd2);
    issue(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd9);
    collect("div_20_m3");
    chk("div_20_m3_k", result_o, 32'hFFFF_FFFA);

    // Back-to-back: stray requests in CALC, real one in FIN
    issue(2'b01, 32'd123457, 32'd11, 5'd10);
    sav_res = exp_res;
    sav_tag = exp_tag;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      div_en = (c == 5 || c == 17 || c == 33);
      if (c == 33) begin
        op_i       = 2'b10;
        dividend_i = 32'hFFFF_0000;
        divisor_i  = 32'd77;
        tag_i      = 5'd11;
        predict(2'b10, 32'hFFFF_0000, 32'd77);
        exp_tag = 5'd11;
      end else begin
        op_i       = 2'($urandom_range(0, 3));
        dividend_i = $urandom;
        divisor_i  = $urandom;
        tag_i      = 5'd31;
      end
      @(posedge clk);
      #1;
      if (c == 33) begin
        chk("b2b_wd_a", {31'd0, wd_en}, 32'd1);
        chk("b2b_res_a", result_o, sav_res);
        chk("b2b_tag_a", {27'd0, tag_o}, {27'd0, sav_tag});
      end else if (c == 5 || c == 17 || c == 32) begin
        chk("b2b_nowd", {31'd0, wd_en}, 32'd0);
      end
    end
    collect("b2b_b");

    // Flush at CALC iteration 10
    issue(2'b00, 32'hDEAD_BEEF, 32'd1234, 5'd12);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      div_en  = 1'b0;
      flush_i = (c == 10);
      @(posedge clk);
      #1;
    end
    m_vld = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_wd", {31'd0, wd_en}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (wd_en) pulses++;
    end
    chk("flush_nopulse", pulses, 32'd0);
    issue(2'b00, 32'hDEAD_BEEF, 32'd1234, 5'd13);
    collect("flush_redo");

    // Reset mid-CALC
    issue(2'b01, 32'd99999, 32'd13, 5'd14);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      div_en = 1'b0;
      rst    = (c == 15);
      @(posedge clk);
      #1;
    end
    m_vld = 1'b0;
    chk("mrst_result", result_o, 32'd0);
    chk("mrst_tag", {27'd0, tag_o}, 32'd0);
    chk("mrst_wd", {31'd0, wd_en}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 32'd1000, 32'd7, 5'd15);
    collect("div_1000_7");
    chk("div_1000_7_k", result_o, 32'd142);
    issue(2'b10, 32'd1000, 32'd7, 5'd16);
    collect("rem_1000_7");
    chk("rem_1000_7_k", result_o, 32'd6);

    // Random ops, biased toward corner cases and cache reuse
    ra = 32'd1;
    rb = 32'd1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rop = 2'($urandom_range(0, 3));
      if (sel == 0) begin
        ra = $urandom;
        rb = 32'd0;
      end else if (sel == 1) begin
        ra = MINV;
        rb = ONES;
      end else if (sel == 2 || sel == 3) begin
        ra = ra;
      end else if (sel == 4) begin
        ra = $urandom;
        rb = 32'($urandom_range(1, 15));
      end else if (sel == 5) begin
        ra = 32'($urandom_range(0, 1000));
        rb = $urandom;
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      issue(rop, ra, rb, 5'($urandom_range(0, 31)));
      collect("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq_rv.md
Name: div_seq_rv

Overview:
- Parametrised, multi-cycle, radix-2 restoring divider for the RV M-extension execute stage.
- Implements DIV, DIVU, REM and REMU exactly to RISC-V semantics, including divide-by-zero and signed overflow.
- Supports flush from the pipeline and carries a writeback tag.
- An optional operand cache returns the companion result (quotient/remainder) of the most recent division in one cycle.

Parameters:
- DW, 32: operand and result width (≥4).
- TAG_W, 5: width of the destination tag carried through (rd index).
- CACHE_EN, 1: 1 enables the last-operation cache; 0 removes it (every op runs full latency).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- div_en  in  1  start request; sampled on the rising edge of clk.
- op_i  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  DW  dividend (rs1).
- divisor_i  in  DW  divisor (rs2).
- tag_i  in  TAG_W  destination tag, captured at accept.
- flush_i  in  1  abort of any in-flight op.
- result_o  out  DW  selected result (quotient for DIV/DIVU, remainder for REM/REMU).
- tag_o  out  TAG_W  tag of result_o.
- wd_en  out  1  one-cycle pulse: result_o/tag_o valid for writeback.
- busy_o  out  1  high while an op is iterating; div_en is ignored while high.

Behaviour:
- Reset (rst high at an edge): state IDLE; result_o=0, tag_o=0, wd_en=0, busy_o=0, iteration counter=0, cache invalid. This applies mid-operation; no result is produced for the aborted op.
- All outputs are registered. States are IDLE, CALC and FIN. busy_o=1 only in CALC.
- Accept: div_en=1 at an edge while the state is IDLE or FIN. At accept, capture op_i, operands and tag_i, and compute magnitudes and the sign flags.
  - Signed ops use two's-complement absolute values.
  - The quotient is negated when the signs differ.
  - The remainder takes the dividend's sign.
- Fast paths: IDLE/FIN go directly to FIN, and wd_en rises 1 cycle after the accept edge. The fast paths are:
  - Divisor zero: quotient = all ones; remainder = dividend (unmodified).
  - Signed overflow (dividend = 1<<(DW-1), divisor = all ones, DIV/REM): quotient = dividend; remainder = 0.
  - Cache hit (CACHE_EN=1, cache valid, operands and signedness equal the cached entry): return the stored quotient or remainder.
- Normal path: go to CALC for exactly DW cycles, one restoring step per cycle, MSB first.
  - Each step computes remainder = {rem, next dividend bit} and subtracts the divisor if the result is ≥ the divisor.
  - After the DW-th step, go to FIN.
  - Apply sign correction in FIN entry logic.
  - wd_en rises DW+1 cycles after the accept edge.
- FIN:
  - wd_en=1 for exactly one cycle; result_o and tag_o are updated on the same edge.
  - On a normal completion, load the cache with operands, signedness, signed quotient and signed remainder.
  - Next state is the accepted path if div_en=1 (back-to-back allowed), otherwise IDLE.
- Output hold: result_o and tag_o hold their values until the next FIN; wd_en=0 outside FIN.
- div_en during CALC: ignored; the request is not queued.
- Flush:
  - flush_i=1 at an edge sends any state to IDLE with wd_en=0 next cycle.
  - Flush overrides div_en in the same cycle and invalidates the cache.
  - A FIN already registered this cycle still shows its wd_en pulse.
- Width rules:
  - Remainder register is DW+1 bits and the counter is $clog2(DW)+1 bits.
  - Negation is modulo 2^DW.
  - No X may reach an output; all state registers are fully reset.
- Unsigned ops treat all inputs as unsigned; op_i[1] selects the result only and does not affect the computation.

Test Plan (DW=32):
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFD, wd_en exactly 33 cycles after accept. Then REM with the same operands (CACHE_EN=1) -> 0xFFFFFFFF, wd_en 1 cycle after accept.
- DIVU 100 / 0 -> 0xFFFFFFFF at latency 1. REMU 100 / 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0; busy_o never asserted for any of these.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF. Then REM 20 / 0xFFFFFFFD (-3) -> 2 (cache miss, full latency). Then DIV 20 / -3 -> 0xFFFFFFFA via cache. tag_o matches each tag_i.
- Back-to-back: hold div_en=1 during FIN with new operands -> new op accepted with no IDLE gap. div_en pulses during CALC are ignored, and no extra wd_en appears.
- flush_i at CALC iteration 10 -> busy_o=0 and state IDLE next cycle, no wd_en. Repeat the same operands -> full 33-cycle latency (cache invalidated) and a correct result.
- rst asserted mid-CALC for one cycle -> all outputs 0 next cycle, no wd_en. The following DIV 1000 / 7 -> 142; REM -> 6.
